sof_encoder: RTL and testbench
==============================

Name: sof_encoder

Overview:
- Serialises a JPEG baseline Start-Of-Frame (SOF0) marker segment into a byte stream for the JPEG output path.
- Operates in the opposite direction to the SOF field parser: it takes frame parameters (precision, height, width, per-component ID, sampling and quantisation table) and emits FF C0, Lf, P, Y, X, Nf and the component triplets.
- The output stream uses a valid/ready handshake so it can feed the bitstream assembler alongside the DQT and DHT emitters.

Parameters:
- MAX_COMP, 3: maximum number of components accepted. Sizes the packed component ports.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to emit a segment. Sampled only in IDLE.
- precision  input  8  sample precision P.
- img_height  input  16  frame height Y.
- img_width  input  16  frame width X.
- num_comp  input  8  component count Nf.
- comp_id  input  8*MAX_COMP  component IDs. Component k occupies bits [8k+7:8k].
- comp_samp  input  8*MAX_COMP  H/V sampling factors (H in the high nibble), same packing.
- comp_qt  input  8*MAX_COMP  quantisation table selectors Tq, same packing.
- out_byte  output  8  current segment byte.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts the byte.
- out_last  output  1  high with the final byte of the segment.
- busy  output  1  high from the cycle after an accepted start until the final handshake.
- done  output  1  one-cycle pulse after the final byte is accepted.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, takes effect immediately; applies mid-segment as well): out_byte=0, out_valid=0, out_last=0, busy=0, done=0, err=0. State returns to IDLE and all latched fields are cleared. No partial segment resumes after reset.
- All inputs are latched on the start cycle. Later changes to the inputs do not affect the segment in flight.
- start while busy is ignored, with no error reported.
- Validity check at start: num_comp==0 or num_comp>MAX_COMP is rejected. err pulses in cycle t+1, busy stays 0, no bytes are emitted, state stays IDLE.
- States: IDLE -> SEND -> IDLE.
  - SEND uses a byte index idx, 0..(9+3*Nf).
  - Total bytes = 10+3*Nf.
- Byte order by idx:
  - 0: 0xFF
  - 1: 0xC0
  - 2: Lf[15:8]
  - 3: Lf[7:0], where Lf = 8+3*Nf as a 16-bit value
  - 4: P
  - 5: Y[15:8]
  - 6: Y[7:0]
  - 7: X[15:8]
  - 8: X[7:0]
  - 9: Nf
  - 10+3k: ID of component k
  - 11+3k: sampling of component k
  - 12+3k: Tq of component k
- Latency: start accepted at cycle t gives out_valid=1 with out_byte=0xFF at cycle t+1, and busy=1 from t+1.
- Handshake:
  - A byte transfers when out_valid && out_ready on a rising edge.
  - While out_valid && !out_ready, out_byte, out_last and out_valid hold stable.
  - out_valid never deasserts mid-segment except on reset.
  - With out_ready held high, one byte transfers per cycle.
- End of segment:
  - On the handshake of the final byte, the next cycle has out_valid=0, out_last=0, busy=0 and done=1 for exactly one cycle.
  - A start arriving in that same done cycle is accepted; back-to-back segments are allowed.
- Zero-valued fields (Y=0, X=0, P=0) are emitted verbatim, with no validation.

Test Plan:
- Grayscale, P=8, Y=256, X=512, Nf=1, ID=01, samp=11, Tq=00, out_ready=1 -> 13 bytes FF C0 00 0B 08 01 00 02 00 01 01 11 00 on consecutive cycles, first byte at t+1. out_last on byte 13, done one cycle later.
- YCbCr, P=8, Y=0x01E0, X=0x0280, Nf=3, (01,22,00)(02,11,01)(03,11,01) -> 19 bytes FF C0 00 11 08 01 E0 02 80 03 01 22 00 02 11 01 03 11 01.
- Backpressure: run the grayscale case with out_ready toggled pseudo-randomly -> identical 13-byte sequence, and out_byte/out_last stable during every stall.
- Rejection: start with Nf=0, then with Nf=4 (MAX_COMP=3) -> err pulses at t+1, out_valid and busy stay 0. A following valid start emits normally.
- Reset mid-segment: assert rst_n=0 after byte 6 of the YCbCr case -> out_valid and busy drop asynchronously. After release, a new start emits from FF C0.
- start pulsed while busy -> ignored and the segment completes unchanged. A start in the done cycle is accepted, and its 0xFF appears on the following cycle.

Source files
------------

// File: rtl/sof_encoder.sv
// JPEG baseline SOF0 marker segment serialiser: latches frame parameters on start
// and streams FF C0, Lf, P, Y, X, Nf and the component triplets over valid/ready.
module sof_encoder #(
  parameter int MAX_COMP = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            precision,
  input  logic [15:0]           img_height,
  input  logic [15:0]           img_width,
  input  logic [7:0]            num_comp,
  input  logic [8*MAX_COMP-1:0] comp_id,
  input  logic [8*MAX_COMP-1:0] comp_samp,
  input  logic [8*MAX_COMP-1:0] comp_qt,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int         IDX_W  = $clog2(10 + 3 * MAX_COMP);
  localparam logic [7:0] MAX_NF = 8'(MAX_COMP);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, last_idx_q;
  logic [1:0]            sub_q;
  logic [7:0]            p_q, nf_q;
  logic [15:0]           y_q, x_q, lf;
  logic [8*MAX_COMP-1:0] id_q, samp_q, qt_q;
  logic                  nf_ok, start_ok, start_bad, xfer, is_last, xfer_last;
  logic                  done_q, err_q;

  assign lf        = 16'd8 + 16'd3 * {8'd0, nf_q};
  assign nf_ok     = (num_comp != 8'd0) && (num_comp <= MAX_NF);
  assign start_ok  = (state_q == IDLE) && start && nf_ok;
  assign start_bad = (state_q == IDLE) && start && !nf_ok;
  assign is_last   = (state_q == SEND) && (idx_q == last_idx_q);
  assign xfer      = (state_q == SEND) && out_ready;
  assign xfer_last = xfer && is_last;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    unique case (state_q)
      IDLE: if (start_ok) state_d = SEND;
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = is_last;
        if (xfer_last) state_d = IDLE;
        case (int'(idx_q))
          0:       out_byte = 8'hFF;
          1:       out_byte = 8'hC0;
          2:       out_byte = lf[15:8];
          3:       out_byte = lf[7:0];
          4:       out_byte = p_q;
          5:       out_byte = y_q[15:8];
          6:       out_byte = y_q[7:0];
          7:       out_byte = x_q[15:8];
          8:       out_byte = x_q[7:0];
          9:       out_byte = nf_q;
          // Component bytes always come from the low byte; the triplet
          // registers shift down once each component has been sent.
          default: begin
            case (sub_q)
              2'd0:    out_byte = id_q[7:0];
              2'd1:    out_byte = samp_q[7:0];
              default: out_byte = qt_q[7:0];
            endcase
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
      sub_q      <= 2'd0;
      p_q        <= 8'h00;
      nf_q       <= 8'h00;
      y_q        <= 16'h0000;
      x_q        <= 16'h0000;
      id_q       <= '0;
      samp_q     <= '0;
      qt_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= xfer_last;
      err_q   <= start_bad;
      if (start_ok) begin
        idx_q      <= '0;
        last_idx_q <= IDX_W'(9 + 3 * int'(num_comp));
        sub_q      <= 2'd0;
        p_q        <= precision;
        nf_q       <= num_comp;
        y_q        <= img_height;
        x_q        <= img_width;
        id_q       <= comp_id;
        samp_q     <= comp_samp;
        qt_q       <= comp_qt;
      end else if (xfer) begin
        idx_q <= idx_q + 1'b1;
        if (int'(idx_q) >= 10) begin
          if (sub_q == 2'd2) begin
            sub_q  <= 2'd0;
            id_q   <= id_q >> 8;
            samp_q <= samp_q >> 8;
            qt_q   <= qt_q >> 8;
          end else begin
            sub_q <= sub_q + 2'd1;
          end
        end
      end
    end
  end

  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sof_encoder.sv
// Directed bench for sof_encoder: table of frame configurations with expected
// byte streams, plus sequences for busy-start, back-to-back and mid-segment reset.
module tb_sof_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  precision;
  logic [15:0] img_height;
  logic [15:0] img_width;
  logic [7:0]  num_comp;
  logic [23:0] comp_id, comp_samp, comp_qt;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready, out_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sof_encoder #(.MAX_COMP(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .precision  (precision),
    .img_height (img_height),
    .img_width  (img_width),
    .num_comp   (num_comp),
    .comp_id    (comp_id),
    .comp_samp  (comp_samp),
    .comp_qt    (comp_qt),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Expected bytes are left-justified: byte n sits at exp[151-8n -: 8].
  typedef struct {
    logic [7:0]   p;
    logic [15:0]  y;
    logic [15:0]  x;
    logic [7:0]   nf;
    logic [23:0]  id;
    logic [23:0]  samp;
    logic [23:0]  qt;
    int           len;
    int           bp;
    logic [151:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic issue(input vec_t v);
    precision  = v.p;
    img_height = v.y;
    img_width  = v.x;
    num_comp   = v.nf;
    comp_id    = v.id;
    comp_samp  = v.samp;
    comp_qt    = v.qt;
    start      = 1'b1;
  endtask

  // Called on the negedge where start is driven; returns on the negedge of the
  // done cycle (or after the reset sequence when rst_at >= 0).
  task automatic drain(input vec_t v, input int poke, input int rst_at);
    int         n = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] pb = 8'h00;
    logic       pl = 1'b0;
    bit         r;
    @(negedge clk);
    start      = 1'b0;
    precision  = 8'hAA;
    img_height = 16'h5A5A;
    img_width  = 16'hA5A5;
    num_comp   = 8'd1;
    comp_id    = 24'hEEEEEE;
    comp_samp  = 24'hDDDDDD;
    comp_qt    = 24'hCCCCCC;
    if (v.len == 0) begin
      check("rej_err", 32'(err), 1);
      check("rej_busy", 32'(busy), 0);
      check("rej_valid", 32'(out_valid), 0);
      @(negedge clk);
      check("rej_err_pulse", 32'(err), 0);
      check("rej_valid2", 32'(out_valid), 0);
      return;
    end
    check("first_busy", 32'(busy), 1);
    check("first_valid", 32'(out_valid), 1);
    while (n < v.len && cyc < 200) begin
      if (rst_at == n) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_byte", 32'(out_byte), 0);
        check("rst_last", 32'(out_last), 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (n == poke);
      if (stalled) begin
        check("stall_byte", 32'(out_byte), 32'(pb));
        check("stall_last", 32'(out_last), 32'(pl));
      end
      check("mid_valid", 32'(out_valid), 1);
      r = (v.bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (r) begin
        check($sformatf("byte%0d", n), 32'(out_byte), 32'(v.exp[151-8*n -: 8]));
        check($sformatf("last%0d", n), 32'(out_last), 32'(n == v.len - 1));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      pb = out_byte;
      pl = out_last;
      cyc++;
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("seg_len", 32'(n), 32'(v.len));
    if (v.bp == 0) check("seg_cycles", 32'(cyc), 32'(v.len));
    check("done", 32'(done), 1);
    check("end_valid", 32'(out_valid), 0);
    check("end_busy", 32'(busy), 0);
    check("end_last", 32'(out_last), 0);
    check("end_err", 32'(err), 0);
  endtask

  initial begin
    vecs[0] = '{8'd8, 16'd256, 16'd512, 8'd1, 24'h000001, 24'h000011, 24'h000000, 13, 0,
                152'hFFC0000B080100020001011100_000000000000};
    vecs[1] = '{8'd8, 16'h01E0, 16'h0280, 8'd3, 24'h030201, 24'h111122, 24'h010100, 19, 0,
                152'hFFC000110801E002800301220002110103110_1};
    vecs[2] = '{8'd0, 16'd0, 16'd0, 8'd2, 24'h000605, 24'h001221, 24'h000302, 16, 0,
                152'hFFC0000E000000000002052102061203_000000};
    vecs[3] = vecs[0];
    vecs[3].bp = 1;
    vecs[4] = '{8'd8, 16'd256, 16'd512, 8'd0, 24'h000001, 24'h000011, 24'h000000, 0, 0, '0};
    vecs[5] = vecs[4];
    vecs[5].nf = 8'd4;
    vecs[6] = vecs[0];

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    precision = '0; img_height = '0; img_width = '0; num_comp = '0;
    comp_id = '0; comp_samp = '0; comp_qt = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_byte", 32'(out_byte), 0);
    check("reset_last", 32'(out_last), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i]);
      drain(vecs[i], -1, -1);
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
    end

    // start while busy is ignored; a start in the done cycle runs back-to-back
    issue(vecs[1]);
    drain(vecs[1], 3, -1);
    issue(vecs[0]);
    drain(vecs[0], -1, -1);
    @(negedge clk);

    // reset after six bytes, then a fresh segment starts from FF C0
    issue(vecs[1]);
    drain(vecs[1], -1, 6);
    issue(vecs[0]);
    drain(vecs[0], -1, -1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
